// File: rtl/codec_config_seq_pkg.sv
// Shared definitions for the codec configuration sequencer: codec register map,
// bus address, default volume and FSM state encoding.
package codec_config_seq_pkg;

    localparam logic [6:0] CODEC_I2C_ADDR = 7'h1A;
    localparam logic [6:0] DEFAULT_VOL    = 7'h79;

    localparam logic [6:0] REG_LHP_VOL   = 7'd2;
    localparam logic [6:0] REG_RHP_VOL   = 7'd3;
    localparam logic [6:0] REG_ANA_PATH  = 7'd4;
    localparam logic [6:0] REG_DIG_PATH  = 7'd5;
    localparam logic [6:0] REG_PWR_DOWN  = 7'd6;
    localparam logic [6:0] REG_DIG_IF    = 7'd7;
    localparam logic [6:0] REG_SAMPLE    = 7'd8;
    localparam logic [6:0] REG_ACTIVE    = 7'd9;
    localparam logic [6:0] REG_RESET     = 7'd15;

    typedef enum logic [2:0] {
        StPwrWait,
        StIssue,
        StWaitAccept,
        StWaitDone,
        StCheck,
        StReady,
        StVolIssue,
        StError
    } cfg_state_e;

    function automatic logic [15:0] cmd_word(input logic [6:0] addr, input logic [8:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// Fixed codec init script: index -> 16-bit command word {reg_addr, reg_data}.
module codec_cfg_rom
    import codec_config_seq_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [15:0]      word_o
);

    always_comb begin
        word_o = 16'h0000;
        case (idx_i)
            IDX_W'(0): word_o = cmd_word(REG_RESET,    9'h000);
            IDX_W'(1): word_o = cmd_word(REG_PWR_DOWN, 9'h010);
            IDX_W'(2): word_o = cmd_word(REG_ANA_PATH, 9'h012);
            IDX_W'(3): word_o = cmd_word(REG_DIG_PATH, 9'h000);
            IDX_W'(4): word_o = cmd_word(REG_DIG_IF,   9'h002);
            IDX_W'(5): word_o = cmd_word(REG_SAMPLE,   9'h000);
            IDX_W'(6): word_o = cmd_word(REG_LHP_VOL,  9'h179);
            IDX_W'(7): word_o = cmd_word(REG_ACTIVE,   9'h001);
            IDX_W'(8): word_o = cmd_word(REG_PWR_DOWN, 9'h000);
            default:   word_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/codec_config_seq.sv
// Codec configuration sequencer: waits for power-up, streams the init script to
// the byte-level I2C master, then services headphone-volume updates.
module codec_config_seq #(
    parameter logic [6:0]  CODEC_I2C_ADDR = codec_config_seq_pkg::CODEC_I2C_ADDR,
    parameter int unsigned POWERUP_CYCLES = 1_000_000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned CFG_LEN        = 9
) (
    input  logic        clk,
    input  logic        rst,
    output logic        i2c_start_o,
    output logic [6:0]  i2c_dev_o,
    output logic [15:0] i2c_word_o,
    input  logic        i2c_busy_i,
    input  logic        i2c_nack_i,
    input  logic        vol_req_i,
    input  logic [6:0]  vol_i,
    output logic        cfg_done_o,
    output logic        cfg_err_o,
    output logic        cfg_busy_o
);
    import codec_config_seq_pkg::*;

    localparam int unsigned PwrW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
    localparam int unsigned RtyW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned IdxW = (CFG_LEN > 1) ? $clog2(CFG_LEN) : 1;

    localparam logic [PwrW-1:0] PwrLast = PwrW'(POWERUP_CYCLES - 1);
    localparam logic [RtyW-1:0] RtyMax  = RtyW'(MAX_RETRY);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(CFG_LEN - 1);

    cfg_state_e      state_q, state_d;
    logic [PwrW-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [RtyW-1:0] retry_q, retry_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [15:0]     word_q, word_d;
    logic [6:0]      vol_q, vol_d;
    logic            done_q, done_d;
    logic            pending_q, pending_d;
    logic            src_vol_q, src_vol_d;
    logic            phase_q, phase_d;
    logic            nack_q, nack_d;
    logic            start;
    logic [IdxW-1:0] rom_idx;
    logic [15:0]     rom_word;

    // In CHECK the ROM looks one entry ahead so the next word is ready on entry to ISSUE.
    assign rom_idx = (state_q == StCheck) ? idx_q + 1'b1 : idx_q;

    codec_cfg_rom #(
        .IDX_W (IdxW)
    ) u_rom (
        .idx_i  (rom_idx),
        .word_o (rom_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StPwrWait;
            pwr_cnt_q <= '0;
            retry_q   <= '0;
            idx_q     <= '0;
            word_q    <= 16'h0000;
            vol_q     <= DEFAULT_VOL;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
            src_vol_q <= 1'b0;
            phase_q   <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pwr_cnt_q <= pwr_cnt_d;
            retry_q   <= retry_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            vol_q     <= vol_d;
            done_q    <= done_d;
            pending_q <= pending_d;
            src_vol_q <= src_vol_d;
            phase_q   <= phase_d;
            nack_q    <= nack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pwr_cnt_d = pwr_cnt_q;
        retry_d   = retry_q;
        idx_d     = idx_q;
        word_d    = word_q;
        vol_d     = vol_q;
        done_d    = done_q;
        pending_d = pending_q;
        src_vol_d = src_vol_q;
        phase_d   = phase_q;
        nack_d    = nack_q;
        start     = 1'b0;

        unique case (state_q)
            StPwrWait: begin
                if (pwr_cnt_q == PwrLast) begin
                    word_d  = rom_word;
                    state_d = StIssue;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            StIssue: begin
                if (!i2c_busy_i) begin
                    start   = 1'b1;
                    state_d = StWaitAccept;
                end
            end
            StWaitAccept: begin
                if (i2c_busy_i) state_d = StWaitDone;
            end
            StWaitDone: begin
                if (!i2c_busy_i) begin
                    nack_d  = i2c_nack_i;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (nack_q) begin
                    if (retry_q < RtyMax) begin
                        retry_d = retry_q + 1'b1;
                        state_d = StIssue;
                    end else begin
                        state_d = StError;
                    end
                end else begin
                    retry_d = '0;
                    if (!src_vol_q) begin
                        if (idx_q < IdxLast) begin
                            idx_d   = idx_q + 1'b1;
                            word_d  = rom_word;
                            state_d = StIssue;
                        end else begin
                            done_d  = 1'b1;
                            state_d = StReady;
                        end
                    end else if (!phase_q) begin
                        // Right channel reuses the data field already sent to the left.
                        phase_d = 1'b1;
                        word_d  = {REG_RHP_VOL, word_q[8:0]};
                        state_d = StIssue;
                    end else begin
                        phase_d   = 1'b0;
                        src_vol_d = 1'b0;
                        state_d   = StReady;
                    end
                end
            end
            StReady: begin
                if (pending_q) state_d = StVolIssue;
            end
            StVolIssue: begin
                pending_d = 1'b0;
                src_vol_d = 1'b1;
                phase_d   = 1'b0;
                word_d    = cmd_word(REG_LHP_VOL, {2'b00, vol_q});
                state_d   = StIssue;
            end
            StError: begin
            end
            default: state_d = StPwrWait;
        endcase

        // Applied last so a request in the dispatch cycle re-arms pending.
        if (vol_req_i && state_q != StError) begin
            vol_d     = vol_i;
            pending_d = 1'b1;
        end
    end

    assign i2c_start_o = start;
    assign i2c_dev_o   = CODEC_I2C_ADDR;
    assign i2c_word_o  = word_q;
    assign cfg_done_o  = done_q;
    assign cfg_err_o   = (state_q == StError);
    assign cfg_busy_o  = !((state_q == StReady && !pending_q) || state_q == StError);

endmodule
